// File: rtl/weight_bank.sv
// weight_bank: double-buffered weight/activation store; a streamed load fills the shadow bank,
// and a commit copies the shadow bank into the active outputs in a single cycle.
module weight_bank #(
    parameter int N1    = 98,
    parameter int N2    = 10,
    parameter int W_K   = 4,
    parameter int W_OUT = 16
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  load_start,
    input  logic                                  s_valid,
    input  logic [W_OUT-1:0]                      s_data,
    output logic                                  s_ready,
    input  logic                                  commit,
    output logic [N2-1:0][N1/2:0][W_K-1:0]        weights_n1_mag,
    output logic [N2-1:0][N1/2:0][W_K-1:0]        weights_n1_pol,
    output logic [N2:0][W_K-1:0]                  weights_n2,
    output logic [2**W_K-1:0][W_OUT-1:0]          tanh,
    output logic                                  busy,
    output logic                                  load_done,
    output logic                                  swapped,
    output logic [7:0]                            generation
);
    localparam int T   = N1/2 + 1;
    localparam int RW  = $clog2(N2);
    localparam int CLW = $clog2(T);
    localparam int NW  = $clog2(N2 + 1);
    localparam int KW  = NW > W_K ? NW : W_K;

    typedef enum logic [2:0] {IDLE, LD_MAG, LD_POL, LD_N2, LD_TANH, DONE} state_t;
    state_t state;

    logic [RW-1:0]  row;
    logic [CLW-1:0] col;
    logic [KW-1:0]  cnt;
    logic [N2-1:0][N1/2:0][W_K-1:0] sh_mag, sh_pol;
    logic [N2:0][W_K-1:0]           sh_n2;
    logic [2**W_K-1:0][W_OUT-1:0]   sh_tanh;
    logic xfer, mat_last, col_last, sec_last;

    // load_start wins over a same-cycle transfer, so that word is dropped
    always_comb begin
        xfer     = s_valid && s_ready && !load_start;
        col_last = col == CLW'(T - 1);
        mat_last = row == RW'(N2 - 1) && col_last;
        sec_last = (state == LD_MAG || state == LD_POL) ? mat_last :
                   state == LD_N2 ? cnt == KW'(N2) : cnt == KW'(2**W_K - 1);
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            if (state == LD_MAG) sh_mag[row][col] <= s_data[W_K-1:0];
            if (state == LD_POL) sh_pol[row][col] <= s_data[W_K-1:0];
            if (state == LD_N2) sh_n2[cnt[NW-1:0]] <= s_data[W_K-1:0];
            if (state == LD_TANH) sh_tanh[cnt[W_K-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            row            <= '0;
            col            <= '0;
            cnt            <= '0;
            s_ready        <= 1'b0;
            busy           <= 1'b0;
            load_done      <= 1'b0;
            swapped        <= 1'b0;
            generation     <= '0;
            weights_n1_mag <= '0;
            weights_n1_pol <= '0;
            weights_n2     <= '0;
            tanh           <= '0;
        end else begin
            swapped <= 1'b0;
            if (commit && state == DONE) begin
                weights_n1_mag <= sh_mag;
                weights_n1_pol <= sh_pol;
                weights_n2     <= sh_n2;
                tanh           <= sh_tanh;
                generation     <= generation + 8'd1;
                swapped        <= 1'b1;
                load_done      <= 1'b0;
                state          <= IDLE;
            end
            // a simultaneous load_start overrides the IDLE target of a commit
            if (load_start) begin
                state     <= LD_MAG;
                row       <= '0;
                col       <= '0;
                cnt       <= '0;
                s_ready   <= 1'b1;
                busy      <= 1'b1;
                load_done <= 1'b0;
            end else if (xfer) begin
                if (sec_last) begin
                    row   <= '0;
                    col   <= '0;
                    cnt   <= '0;
                    state <= state == LD_MAG ? LD_POL : state == LD_POL ? LD_N2 :
                             state == LD_N2 ? LD_TANH : DONE;
                    if (state == LD_TANH) begin
                        s_ready   <= 1'b0;
                        busy      <= 1'b0;
                        load_done <= 1'b1;
                    end
                end else if (state == LD_MAG || state == LD_POL) begin
                    col <= col_last ? '0 : col + 1'b1;
                    if (col_last) row <= row + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
